// File: rtl/decompress_stream.sv
// -----------------------------------------------------------------------------
// decompress_stream
//   Multi-lane Kyber decompression with a per-beat compression width.
//   Each lane computes out = round(x*3329 / 2^d) = (x*3329 + 2^(d-1)) >> d.
//   A 3-stage valid/ready pipeline (S1 mask, S2 partial products, S3 round and
//   shift) with one common enable, so the whole pipe advances or holds together.
//   The last beat of every N_COEF-coefficient polynomial is tagged.
//
// Ports
//   clk        clock, all logic on posedge
//   rst        synchronous active-high reset
//   in_valid   input beat valid
//   in_ready   block can accept a beat (combinational from out side)
//   in_d       compression width d for this beat (legal 1..DMAX)
//   in_data    LANES slots of DMAX bits, lane i = in_data[i*DMAX +: DMAX]
//   out_valid  output beat valid
//   out_ready  downstream accepts
//   out_data   LANES x 12-bit results, lane i = out_data[i*12 +: 12]
//   out_last   beat is last of its polynomial
//   err        sticky flag: a beat with illegal d was accepted
// -----------------------------------------------------------------------------
module decompress_stream #(
    parameter int LANES  = 4,
    parameter int DMAX   = 11,
    parameter int N_COEF = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [3:0]            in_d,
    input  logic [LANES*DMAX-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [LANES*12-1:0]   out_data,
    output logic                  out_last,
    output logic                  err
);

    localparam int         BEATS  = N_COEF / LANES;
    localparam int         CW     = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);
    // x*3329 needs DMAX+12 bits; the rounding constant still fits.
    localparam int         PW     = DMAX + 12;
    localparam logic [3:0] DMAX_D = 4'(DMAX);

    // Common enable: the pipe moves unless the output is held by backpressure.
    logic en;
    assign en       = out_ready | ~out_valid;
    assign in_ready = en;

    logic                 in_ok;
    logic [DMAX-1:0]      in_mask;
    assign in_ok   = (in_d != 4'd0) && (in_d <= DMAX_D);
    assign in_mask = ~({DMAX{1'b1}} << in_d);

    // Per-stage control that travels with the data.
    logic       s1_valid_reg, s2_valid_reg, out_valid_reg;
    logic [3:0] s1_d_reg, s2_d_reg;
    logic       s1_ok_reg, s2_ok_reg;
    logic [CW-1:0] cnt_reg;
    logic       err_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_reg  <= 1'b0;
            s2_valid_reg  <= 1'b0;
            out_valid_reg <= 1'b0;
            s1_d_reg      <= 4'd0;
            s2_d_reg      <= 4'd0;
            s1_ok_reg     <= 1'b0;
            s2_ok_reg     <= 1'b0;
        end else if (en) begin
            s1_valid_reg  <= in_valid;
            s2_valid_reg  <= s1_valid_reg;
            out_valid_reg <= s2_valid_reg;
            s1_d_reg      <= in_d;
            s2_d_reg      <= s1_d_reg;
            s1_ok_reg     <= in_ok;
            s2_ok_reg     <= s1_ok_reg;
        end
    end

    // Beat counter advances on output handshakes only, so out_last is stable
    // for as long as the output beat is stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg <= '0;
        end else if (out_valid_reg && out_ready) begin
            cnt_reg <= (cnt_reg == LAST_BEAT) ? '0 : cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_reg <= 1'b0;
        end else if (in_valid && en && !in_ok) begin
            err_reg <= 1'b1;
        end
    end

    // Rounding constant 2^(d-1); for illegal d the lane result is forced to 0
    // so the wrapped shift amount never matters.
    logic [PW-1:0] rnd;
    assign rnd = PW'(1) << (s2_d_reg - 4'd1);

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            logic [DMAX-1:0] x_next, x_reg;
            logic [PW-1:0]   xw, a_reg, b_reg, sum;
            logic [11:0]     r_next, r_reg;

            // S1: drop bits at or above d; illegal d yields a zero lane.
            always_comb begin
                x_next = in_data[gi*DMAX +: DMAX] & in_mask;
                if (!in_ok) begin
                    x_next = '0;
                end
            end

            // S2: 3329 = 2^11 + 2^10 + 2^8 + 1, split into two shift-add terms.
            assign xw  = PW'(x_reg);
            assign sum = a_reg + b_reg + rnd;

            // S3: round and scale down by 2^d.
            always_comb begin
                r_next = 12'(sum >> s2_d_reg);
                if (!s2_ok_reg) begin
                    r_next = 12'd0;
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    x_reg <= '0;
                    a_reg <= '0;
                    b_reg <= '0;
                    r_reg <= '0;
                end else if (en) begin
                    x_reg <= x_next;
                    a_reg <= (xw << 11) + (xw << 10);
                    b_reg <= (xw << 8) + xw;
                    r_reg <= r_next;
                end
            end

            assign out_data[gi*12 +: 12] = r_reg;
        end
    endgenerate

    assign out_valid = out_valid_reg;
    assign out_last  = out_valid_reg && (cnt_reg == LAST_BEAT);
    assign err       = err_reg;

endmodule

// File: tb/tb_decompress_stream.sv
// -----------------------------------------------------------------------------
// tb_decompress_stream
//   Self-checking bench for decompress_stream. A reference model computes each
//   lane as round-half-up of (x mod 2^d)*3329/2^d with plain integer math, and
//   a queue holds expected beats in acceptance order.
// -----------------------------------------------------------------------------
module tb_decompress_stream;

    localparam int LANES = 4;
    localparam int DMAX  = 11;
    localparam int NCOEF = 256;
    localparam int BPP   = NCOEF / LANES;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_d;
    logic [43:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [47:0] out_data;
    logic        out_last;
    logic        err;

    int total = 0;
    int bad   = 0;

    logic [47:0] exp_q[$];

    always #5 clk = ~clk;

    decompress_stream #(.LANES(LANES), .DMAX(DMAX), .N_COEF(NCOEF)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_d(in_d), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .err(err)
    );

    function automatic int ref_lane(input int x, input int d);
        int xm;
        if (d < 1 || d > DMAX) return 0;
        xm = x % (1 << d);
        return (xm * 3329 + (1 << d) / 2) / (1 << d);
    endfunction

    function automatic logic [47:0] model_beat(input logic [3:0] d, input logic [43:0] data);
        logic [47:0] r;
        r = '0;
        for (int i = 0; i < LANES; i++) begin
            r[i*12 +: 12] = 12'(ref_lane(int'(data[i*11 +: 11]), int'(d)));
        end
        return r;
    endfunction

    function automatic logic [43:0] pack4(input int l0, input int l1, input int l2, input int l3);
        logic [43:0] p;
        p[10:0]  = 11'(l0);
        p[21:11] = 11'(l1);
        p[32:22] = 11'(l2);
        p[43:33] = 11'(l3);
        return p;
    endfunction

    function automatic logic [3:0] pick_d();
        case ($urandom_range(0, 4))
            0: return 4'd1;
            1: return 4'd4;
            2: return 4'd5;
            3: return 4'd10;
            default: return 4'd11;
        endcase
    endfunction

    function automatic logic [43:0] rand_data();
        return pack4($urandom_range(0, 2047), $urandom_range(0, 2047),
                     $urandom_range(0, 2047), $urandom_range(0, 2047));
    endfunction

    // One bus cycle: drive at posedge+1, sample at posedge+2, then advance to
    // the next posedge+1. Keeps the model queue in step; performs no checks.
    task automatic cycle(input logic v, input logic [3:0] d, input logic [43:0] data,
                         input logic rdy, output logic acc, output logic emit,
                         output logic vis, output logic [47:0] got, output logic [47:0] exp,
                         output logic last, output logic rdy_ok, output logic orphan);
        in_valid  = v;
        in_d      = d;
        in_data   = data;
        out_ready = rdy;
        #1;
        acc    = v && in_ready;
        vis    = out_valid;
        emit   = out_valid && rdy;
        got    = out_data;
        last   = out_last;
        rdy_ok = (in_ready === (!out_valid || rdy));
        orphan = 1'b0;
        exp    = '0;
        if (emit) begin
            if (exp_q.size() == 0) orphan = 1'b1;
            else exp = exp_q.pop_front();
        end
        if (acc) exp_q.push_back(model_beat(d, data));
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_d      = 4'd0;
        in_data   = '0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        total++; if (out_data !== 48'd0) begin bad++; $display("FAIL reset_out_data got=%h want=0", out_data); end
        total++; if (out_last !== 1'b0) begin bad++; $display("FAIL reset_out_last got=%b want=0", out_last); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b want=0", err); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    endtask

    task automatic test_basic();
        logic acc, emit, vis, last, rok, orph;
        logic [47:0] got, exp;
        logic [47:0] want;
        want = {12'd208, 12'd3121, 12'd1665, 12'd0};
        for (int c = 0; c < 4; c++) begin
            cycle(c == 0, 4'd4, pack4(0, 8, 15, 1), 1'b1, acc, emit, vis, got, exp, last, rok, orph);
            total++;
            if (vis !== (c == 3)) begin bad++; $display("FAIL basic_latency cycle=%0d got=%b want=%b", c, vis, c == 3); end
            if (c == 3) begin
                total++; if (got !== want) begin bad++; $display("FAIL basic_data got=%h want=%h", got, want); end
                total++; if (orph || got !== exp) begin bad++; $display("FAIL basic_model got=%h want=%h", got, exp); end
                total++; if (err !== 1'b0) begin bad++; $display("FAIL basic_err got=%b want=0", err); end
            end
        end
        $display("basic: d=4 beat out=%h", got);
    endtask

    task automatic test_back_to_back();
        logic acc, emit, vis, last, rok, orph;
        logic [47:0] got, exp;
        logic [3:0]  dt[4];
        int          xt[4];
        int          wt[4];
        dt = '{4'd10, 4'd11, 4'd1, 4'd5};
        xt = '{1023, 2047, 1, 16};
        wt = '{3326, 3327, 1665, 1665};
        for (int c = 0; c < 8; c++) begin
            if (c < 4)
                cycle(1'b1, dt[c], pack4(xt[c], xt[c], xt[c], xt[c]), 1'b1, acc, emit, vis, got, exp, last, rok, orph);
            else
                cycle(1'b0, 4'd0, '0, 1'b1, acc, emit, vis, got, exp, last, rok, orph);
            total++;
            if (emit !== (c >= 3 && c <= 6)) begin bad++; $display("FAIL b2b_timing cycle=%0d got=%b want=%b", c, emit, (c >= 3 && c <= 6)); end
            if (emit && c >= 3 && c <= 6) begin
                total++;
                if (got !== {4{12'(wt[c-3])}} || orph || got !== exp) begin
                    bad++; $display("FAIL b2b_data beat=%0d got=%h want=%h", c - 3, got, {4{12'(wt[c-3])}});
                end
                $display("b2b: beat %0d d=%0d out=%h", c - 3, dt[c-3], got);
            end
        end
    endtask

    task automatic test_illegal();
        logic acc, emit, vis, last, rok, orph;
        logic [47:0] got, exp;
        logic [3:0]  dt[4];
        logic [43:0] dat[4];
        logic [47:0] wt[4];
        int          k;
        dt  = '{4'd4, 4'd0, 4'd12, 4'd11};
        dat = '{pack4(12'h3F8, 12'h3F8, 12'h3F8, 12'h3F8), rand_data(), rand_data(), pack4(2047, 2047, 2047, 2047)};
        wt  = '{{4{12'd1665}}, 48'd0, 48'd0, {4{12'd3327}}};
        k = 0;
        for (int c = 0; c < 8; c++) begin
            cycle(c < 4, (c < 4) ? dt[c] : 4'd0, (c < 4) ? dat[c] : 44'd0, 1'b1,
                  acc, emit, vis, got, exp, last, rok, orph);
            total++;
            if (err !== (c >= 1)) begin bad++; $display("FAIL illegal_err cycle=%0d got=%b want=%b", c, err, c >= 1); end
            if (emit) begin
                total++;
                if (k > 3 || got !== wt[k] || orph || got !== exp) begin
                    bad++; $display("FAIL illegal_data beat=%0d got=%h want=%h", k, got, (k > 3) ? 48'd0 : wt[k]);
                end
                $display("illegal: beat %0d out=%h err=%b", k, got, err);
                k++;
            end
        end
        total++; if (k !== 4) begin bad++; $display("FAIL illegal_count got=%0d want=4", k); end
    endtask

    task automatic test_backpressure();
        logic acc, emit, vis, last, rok, orph, rdy;
        logic [47:0] got, exp, pgot;
        logic        pstall, plast;
        logic [3:0]  d;
        logic [43:0] data;
        int          sent, recv;
        pstall = 1'b0; plast = 1'b0; pgot = '0; sent = 0; recv = 0;
        d = pick_d(); data = rand_data();
        for (int c = 0; c < 120; c++) begin
            if (c >= 6 && c < 11) rdy = 1'b0;
            else rdy = ($urandom_range(0, 2) != 0);
            cycle(sent < 10, d, data, rdy, acc, emit, vis, got, exp, last, rok, orph);
            total++;
            if (!rok) begin bad++; $display("FAIL bp_in_ready cycle=%0d got=%b want=%b", c, in_ready, !vis || rdy); end
            if (pstall) begin
                total++;
                if (vis !== 1'b1 || got !== pgot || last !== plast) begin
                    bad++; $display("FAIL bp_hold cycle=%0d got=%h want=%h", c, got, pgot);
                end
            end
            if (emit) begin
                total++;
                if (orph || got !== exp) begin bad++; $display("FAIL bp_data beat=%0d got=%h want=%h", recv, got, exp); end
                $display("bp: beat %0d out=%h", recv, got);
                recv++;
            end
            pstall = vis && !rdy;
            pgot = got;
            plast = last;
            if (acc) begin sent++; d = pick_d(); data = rand_data(); end
        end
        total++; if (recv !== 10) begin bad++; $display("FAIL bp_count got=%0d want=10", recv); end
    endtask

    task automatic test_framing();
        logic acc, emit, vis, last, rok, orph;
        logic [47:0] got, exp;
        int          sent, recv;
        sent = 0; recv = 0;
        do_reset();
        for (int c = 0; c < 140; c++) begin
            cycle(sent < 2 * BPP, pick_d(), rand_data(), 1'b1, acc, emit, vis, got, exp, last, rok, orph);
            if (vis) begin
                total++;
                if (last !== (recv == BPP - 1 || recv == 2 * BPP - 1)) begin
                    bad++; $display("FAIL frame_last beat=%0d got=%b want=%b", recv, last, (recv == BPP - 1 || recv == 2 * BPP - 1));
                end
            end
            if (emit) begin
                total++;
                if (orph || got !== exp) begin bad++; $display("FAIL frame_data beat=%0d got=%h want=%h", recv, got, exp); end
                if (last) $display("frame: last at beat %0d", recv);
                recv++;
            end
            if (acc) sent++;
        end
        total++; if (recv !== 2 * BPP) begin bad++; $display("FAIL frame_count got=%0d want=%0d", recv, 2 * BPP); end
    endtask

    task automatic test_mid_reset();
        logic acc, emit, vis, last, rok, orph;
        logic [47:0] got, exp;
        int          sent, recv;
        do_reset();
        // Five beats (first illegal): two drain out, three remain in flight.
        for (int c = 0; c < 5; c++) begin
            cycle(1'b1, (c == 0) ? 4'd0 : pick_d(), rand_data(), 1'b1, acc, emit, vis, got, exp, last, rok, orph);
        end
        total++; if (err !== 1'b1) begin bad++; $display("FAIL mrst_err_before got=%b want=1", err); end
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mrst_out_valid got=%b want=0", out_valid); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL mrst_err got=%b want=0", err); end
        total++; if (out_last !== 1'b0) begin bad++; $display("FAIL mrst_out_last got=%b want=0", out_last); end
        for (int c = 0; c < 3; c++) begin
            cycle(1'b0, 4'd0, '0, 1'b1, acc, emit, vis, got, exp, last, rok, orph);
            total++; if (vis !== 1'b0) begin bad++; $display("FAIL mrst_flush cycle=%0d got=%b want=0", c, vis); end
        end
        sent = 0; recv = 0;
        for (int c = 0; c < 75; c++) begin
            cycle(sent < BPP, pick_d(), rand_data(), 1'b1, acc, emit, vis, got, exp, last, rok, orph);
            if (emit) begin
                total++;
                if (orph || got !== exp || last !== (recv == BPP - 1)) begin
                    bad++; $display("FAIL mrst_data beat=%0d got=%h/%b want=%h/%b", recv, got, last, exp, recv == BPP - 1);
                end
                if (recv == 0 || last) $display("mrst: beat %0d out=%h last=%b", recv, got, last);
                recv++;
            end
            if (acc) sent++;
        end
        total++; if (recv !== BPP) begin bad++; $display("FAIL mrst_count got=%0d want=%0d", recv, BPP); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_d      = 4'd0;
        in_data   = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_basic();
        test_back_to_back();
        test_illegal();
        test_backpressure();
        test_framing();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
